xorshift_rewind: RTL

//  Iterative inverse of one xorshift PRNG step (x^=x<<A; x^=x>>B; x^=x<<C): given the current state,

---
 rtl/xorshift_rewind_pkg.sv | 24 ++
 rtl/xorshift_step.sv | 21 ++
 rtl/xorshift_rewind.sv | 128 ++++++++++++
 3 files changed

// File: rtl/xorshift_rewind_pkg.sv
// Shared PRNG definitions: default width/shift amounts, rewind FSM encoding, iteration count.
package xorshift_rewind_pkg;

  localparam int PRNG_WIDTH  = 16;
  localparam int SHIFT_A_DEF = 7;
  localparam int SHIFT_B_DEF = 9;
  localparam int SHIFT_C_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNDO_C = 3'd1,
    UNDO_B = 3'd2,
    UNDO_A = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Shift-XOR terms needed to invert x ^= x<<s (or >>s) on w bits.
  function automatic int n_iter(input int w, input int s);
    int n;
    n = (w + s - 1) / s - 1;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/xorshift_step.sv
// Combinational forward xorshift step: x^=x<<A; x^=x>>B; x^=x<<C.
module xorshift_step
  import xorshift_rewind_pkg::*;
#(
  parameter int WIDTH   = PRNG_WIDTH,
  parameter int SHIFT_A = SHIFT_A_DEF,
  parameter int SHIFT_B = SHIFT_B_DEF,
  parameter int SHIFT_C = SHIFT_C_DEF
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  assign s1 = x ^ (x << SHIFT_A);
  assign s2 = s1 ^ (s1 >> SHIFT_B);
  assign y  = s2 ^ (s2 << SHIFT_C);

endmodule

// File: rtl/xorshift_rewind.sv
// Iterative inverse of one xorshift step, one shift-XOR term per clock.
// Optional self-check of the recovered state: define XORSHIFT_REWIND_CHECK_EN.
module xorshift_rewind
  import xorshift_rewind_pkg::*;
#(
  parameter int WIDTH   = PRNG_WIDTH,
  parameter int SHIFT_A = SHIFT_A_DEF,
  parameter int SHIFT_B = SHIFT_B_DEF,
  parameter int SHIFT_C = SHIFT_C_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             chk_err
);

  localparam int N_C   = n_iter(WIDTH, SHIFT_C);
  localparam int N_B   = n_iter(WIDTH, SHIFT_B);
  localparam int N_A   = n_iter(WIDTH, SHIFT_A);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, term;
  logic [WIDTH-1:0] t_nxt, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic             capture, busy, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign capture   = in_valid && in_ready;
  assign busy      = (state == UNDO_C) || (state == UNDO_B) || (state == UNDO_A);
  assign acc_nxt   = acc ^ t_nxt;
  assign last      = (cnt == cnt_last);

  // Stages run in reverse order of the forward step: C, then B, then A.
  always_comb begin
    t_nxt    = term;
    cnt_last = '0;
    case (state)
      UNDO_C: begin
        t_nxt    = term << SHIFT_C;
        cnt_last = CNT_W'(N_C - 1);
      end
      UNDO_B: begin
        t_nxt    = term >> SHIFT_B;
        cnt_last = CNT_W'(N_B - 1);
      end
      UNDO_A: begin
        t_nxt    = term << SHIFT_A;
        cnt_last = CNT_W'(N_A - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture)   state_nxt = UNDO_C;
      UNDO_C:  if (last)      state_nxt = UNDO_B;
      UNDO_B:  if (last)      state_nxt = UNDO_A;
      UNDO_A:  if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        acc <= in_data;
        cnt <= '0;
      end else if (busy) begin
        acc <= acc_nxt;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  // Each new stage restarts its term chain from the partially recovered value.
  always_ff @(posedge clk) begin
    if (capture)   term <= in_data;
    else if (busy) term <= last ? acc_nxt : t_nxt;
  end

`ifdef XORSHIFT_REWIND_CHECK_EN
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] fwd;
  logic             chk_err_r;

  xorshift_step #(
    .WIDTH  (WIDTH),
    .SHIFT_A(SHIFT_A),
    .SHIFT_B(SHIFT_B),
    .SHIFT_C(SHIFT_C)
  ) u_step (
    .x(acc_nxt),
    .y(fwd)
  );

  always_ff @(posedge clk) begin
    if (capture) cap <= in_data;
  end

  // Evaluated on the value about to be written into acc as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      chk_err_r <= 1'b0;
    else if (capture)                chk_err_r <= 1'b0;
    else if (state == UNDO_A && last) chk_err_r <= (fwd != cap);
  end

  assign chk_err = chk_err_r;
`else
  assign chk_err = 1'b0;
`endif

endmodule
